ik_swift_iter: RTL and testbench
================================

IK_SWIFT_ITER -- requirements
Module: ik_swift_iter

Interface
REQ-001 The block SHALL have parameter N_JOINT, default 6, giving the number of joints.
REQ-002 The block SHALL have parameter W, default 36, giving the two's-complement fixed-point word width.
REQ-003 The block SHALL have parameter MAX_ITER, default 64, giving the iteration limit; IW = $clog2(MAX_ITER+1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: clock enable; while low, all state holds.
REQ-007 The block SHALL have port start, input, 1 bit: begin a solve; sampled only in IDLE.
REQ-008 The block SHALL have port init_param, input, N_JOINT x W: initial joint variables.
REQ-009 The block SHALL have port joint_lock, input, N_JOINT bits: bit i=1 freezes joint i.
REQ-010 The block SHALL have port epsilon, input, W bits: convergence threshold, signed.
REQ-011 The block SHALL have port solver_start, output, 1 bit: one-cycle pulse requesting one DLS step.
REQ-012 The block SHALL have port solver_done, input, 1 bit: delta is valid this cycle.
REQ-013 The block SHALL have port delta, input, N_JOINT x W: per-joint update from the solver.
REQ-014 The block SHALL have port theta, output, N_JOINT x W: current joint variables, fed back as dh_param.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a solve.
REQ-017 The block SHALL have port converged, output, 1 bit: result flag of the last solve.
REQ-018 The block SHALL have port iter_count, output, IW bits: number of completed iterations.

Function
REQ-019 The block SHALL implement the states IDLE, ISSUE, WAIT, UPDATE, CHECK and FIN; all transitions SHALL occur only on clk edges where en=1.
REQ-020 IDLE with start=1: the block SHALL load theta<=init_param, clear iter_count and converged, and go to ISSUE.
REQ-021 ISSUE: solver_start SHALL be 1 (combinational decode of the state) and the block SHALL go to WAIT next edge; solver_start SHALL therefore go high the cycle after start is accepted.
REQ-022 WAIT: the block SHALL hold until solver_done=1, then register all delta words, clear joint index j, set all_small=1, and go to UPDATE.
REQ-023 UPDATE: the block SHALL process one joint per cycle, j=0..N_JOINT-1, and leave after N_JOINT cycles.
REQ-024 UPDATE, unlocked joint: theta[j]<=sat(theta[j]+delta[j]), using a W+1-bit sum clamped to [-2^(W-1), 2^(W-1)-1].
REQ-025 UPDATE, unlocked joint: if |delta[j]|>=epsilon the block SHALL clear all_small; |(-2^(W-1))| SHALL be treated as the maximum magnitude, never small.
REQ-026 UPDATE, locked joint (lock bit sampled in that cycle): theta[j] SHALL be unchanged and the joint SHALL not affect all_small.
REQ-027 On leaving UPDATE, iter_count SHALL increment by 1 and the block SHALL go to CHECK.
REQ-028 CHECK: if all_small=1, the block SHALL set converged=1 and go to FIN; else if iter_count==MAX_ITER, converged=0 and FIN; else ISSUE.
REQ-029 FIN: done SHALL be 1 for exactly one cycle, then the block SHALL go to IDLE; theta, iter_count and converged SHALL hold until the next accepted start.
REQ-030 With all joints locked, the solve SHALL converge after exactly 1 iteration.
REQ-031 A negative epsilon SHALL never allow convergence, so the block runs MAX_ITER iterations.
REQ-032 start outside IDLE SHALL be ignored; solver_done outside WAIT SHALL be ignored.
REQ-033 en=0 during WAIT with solver_done=1 SHALL not capture delta; the solver must hold solver_done until it is accepted.
REQ-034 Latency per iteration SHALL be 1 (ISSUE) + solver wait + N_JOINT (UPDATE) + 1 (CHECK) cycles.

Reset
REQ-035 When rst=0 at a clk edge, regardless of en or state, the block SHALL enter IDLE, clear theta, iter_count, converged, done, busy and solver_start, and clear j and the delta registers.
REQ-036 A reset mid-solve SHALL abort the solve without a done pulse.

Verification (N_JOINT=6, W=36, MAX_ITER=64; one fixed-point unit = 1.0 = 2^16)
REQ-037 Single-step converge: init 0, epsilon=0x100, solver returns delta=0x80 for all joints -> one iteration, theta=0x80 each, converged=1, iter_count=1, done pulsed once.
REQ-038 Iteration limit: delta=0x10000 on every step, epsilon=0x100 -> 64 solver_start pulses, theta=64.0 each, converged=0, iter_count=64.
REQ-039 Saturation: theta[0] init 0x7_FFFF_FFF0, delta[0]=0x100 -> theta[0]=0x7_FFFF_FFFF; negative case clamps to 0x8_0000_0000.
REQ-040 Lock and min-value: joint_lock=6'b000001 with delta[0]=0x8_0000_0000 and other deltas 0 -> theta[0] unchanged, converged=1 after one iteration; unlocked, the same delta blocks convergence.
REQ-041 Handshake hygiene: start pulsed while busy, spurious solver_done in UPDATE, en held low for 5 cycles in WAIT -> no state change and no extra iteration; iteration counts match REQ-034.
REQ-042 Reset mid-UPDATE (j=3): rst=0 for one cycle -> IDLE, all outputs 0, no done pulse; a new start then runs normally.

Source files
------------

// File: rtl/ik_swift_iter.sv
// Iterative inverse-kinematics controller: issues DLS solver steps, applies saturated
// per-joint updates one joint per cycle, and stops on convergence or the iteration limit.
module ik_swift_iter #(
  parameter int N_JOINT  = 6,
  parameter int W        = 36,
  parameter int MAX_ITER = 64,
  localparam int IW      = $clog2(MAX_ITER + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       start,
  input  logic [N_JOINT-1:0][W-1:0]  init_param,
  input  logic [N_JOINT-1:0]         joint_lock,
  input  logic [W-1:0]               epsilon,
  output logic                       solver_start,
  input  logic                       solver_done,
  input  logic [N_JOINT-1:0][W-1:0]  delta,
  output logic [N_JOINT-1:0][W-1:0]  theta,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [IW-1:0]              iter_count
);

  localparam int JW = (N_JOINT > 1) ? $clog2(N_JOINT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_CHECK, S_FIN
  } state_t;

  state_t                      state_q, state_d;
  logic [N_JOINT-1:0][W-1:0]   theta_q, theta_d;
  logic [N_JOINT-1:0][W-1:0]   delta_q, delta_d;
  logic [JW-1:0]               j_q, j_d;
  logic                        all_small_q, all_small_d;
  logic [IW-1:0]               iter_q, iter_d;
  logic                        conv_q, conv_d;

  logic [W-1:0] cur_theta, cur_delta, delta_mag, sat_val;
  logic [W:0]   sum;
  logic         delta_big;

  // Saturating add and magnitude test for the joint currently addressed by j.
  always_comb begin
    cur_theta = theta_q[j_q];
    cur_delta = delta_q[j_q];
    sum       = {cur_theta[W-1], cur_theta} + {cur_delta[W-1], cur_delta};
    if (sum[W] != sum[W-1])
      sat_val = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_val = sum[W-1:0];
    // The most negative value negates to 2^(W-1) as unsigned: largest magnitude.
    delta_mag = cur_delta[W-1] ? (~cur_delta + W'(1)) : cur_delta;
    delta_big = epsilon[W-1] || (delta_mag >= epsilon);
  end

  always_comb begin
    state_d     = state_q;
    theta_d     = theta_q;
    delta_d     = delta_q;
    j_d         = j_q;
    all_small_d = all_small_q;
    iter_d      = iter_q;
    conv_d      = conv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          theta_d = init_param;
          iter_d  = '0;
          conv_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (solver_done) begin
          delta_d     = delta;
          j_d         = '0;
          all_small_d = 1'b1;
          state_d     = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (!joint_lock[j_q]) begin
          theta_d[j_q] = sat_val;
          if (delta_big) all_small_d = 1'b0;
        end
        if (j_q == JW'(N_JOINT - 1)) begin
          iter_d  = iter_q + IW'(1);
          state_d = S_CHECK;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_CHECK: begin
        if (all_small_q) begin
          conv_d  = 1'b1;
          state_d = S_FIN;
        end else if (iter_q == IW'(MAX_ITER)) begin
          conv_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      theta_q     <= '0;
      delta_q     <= '0;
      j_q         <= '0;
      all_small_q <= 1'b0;
      iter_q      <= '0;
      conv_q      <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      theta_q     <= theta_d;
      delta_q     <= delta_d;
      j_q         <= j_d;
      all_small_q <= all_small_d;
      iter_q      <= iter_d;
      conv_q      <= conv_d;
    end
  end

  assign theta        = theta_q;
  assign iter_count   = iter_q;
  assign converged    = conv_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign solver_start = (state_q == S_ISSUE);

endmodule

// File: tb/tb_ik_swift_iter.sv
// Directed self-checking bench for ik_swift_iter with a behavioural solver responder.
module tb_ik_swift_iter;

  localparam int NJ = 6;
  localparam int W  = 36;
  localparam int MI = 64;
  localparam int IW = $clog2(MI + 1);

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  start;
  logic [NJ-1:0][W-1:0]  init_param;
  logic [NJ-1:0]         joint_lock;
  logic [W-1:0]          epsilon;
  logic                  solver_start;
  logic                  solver_done;
  logic [NJ-1:0][W-1:0]  delta;
  logic [NJ-1:0][W-1:0]  theta;
  logic                  busy;
  logic                  done;
  logic                  converged;
  logic [IW-1:0]         iter_count;

  int errors = 0;
  int checks = 0;
  int n_start;
  int n_done;
  int done_cyc;
  logic [NJ-1:0][W-1:0] exp_theta;

  ik_swift_iter #(.N_JOINT(NJ), .W(W), .MAX_ITER(MI)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .init_param(init_param),
    .joint_lock(joint_lock), .epsilon(epsilon), .solver_start(solver_start),
    .solver_done(solver_done), .delta(delta), .theta(theta), .busy(busy),
    .done(done), .converged(converged), .iter_count(iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a solve and answers every solver_start after lat extra WAIT cycles.
  // Cycle 0 is the first cycle after start is accepted (the ISSUE cycle).
  task automatic run_solve(input int lat, input int limit);
    int cnt;
    bit pending;
    n_start  = 0;
    n_done   = 0;
    done_cyc = -1;
    pending  = 1'b0;
    cnt      = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      solver_done = 1'b0;
      if (solver_start) begin
        n_start++;
        pending = 1'b1;
        cnt     = lat;
      end else if (pending) begin
        if (cnt == 0) begin
          solver_done = 1'b1;
          pending     = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    solver_done = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL solve_timeout: no done within %0d cycles (iter_count=%0d)", limit, iter_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; start = 1'b0; solver_done = 1'b0;
    init_param = '0; joint_lock = '0; epsilon = '0; delta = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, solver_start, converged} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 0000", {busy, done, solver_start, converged});
    end
    checks++;
    if (theta !== '0) begin
      errors++;
      $display("FAIL reset_theta: got %h, expected 0", theta);
    end
    checks++;
    if (iter_count !== '0) begin
      errors++;
      $display("FAIL reset_iter: got %0d, expected 0", iter_count);
    end
    rst = 1'b1; en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_step();
    init_param = '0; joint_lock = '0; epsilon = 36'h100;
    for (int i = 0; i < NJ; i++) delta[i] = 36'h80;
    for (int i = 0; i < NJ; i++) exp_theta[i] = 36'h80;
    run_solve(2, 200);
    checks++;
    if (theta !== exp_theta) begin
      errors++;
      $display("FAIL single_theta: got %h, expected %h", theta, exp_theta);
    end
    checks++;
    if ({converged, iter_count} !== {1'b1, IW'(1)}) begin
      errors++;
      $display("FAIL single_result: conv=%b iter=%0d, expected conv=1 iter=1", converged, iter_count);
    end
    checks++;
    if (n_done !== 1 || n_start !== 1) begin
      errors++;
      $display("FAIL single_pulses: done=%0d start=%0d, expected 1 and 1", n_done, n_start);
    end
    checks++;
    if (done_cyc !== 11) begin
      errors++;
      $display("FAIL single_latency: done at cycle %0d, expected 11", done_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_handshake();
    logic [NJ-1:0][W-1:0] good;
    logic [NJ-1:0][W-1:0] spurious;
    for (int i = 0; i < NJ; i++) good[i] = 36'h80;
    for (int i = 0; i < NJ; i++) spurious[i] = 36'h5000;
    init_param = '0; joint_lock = '0; epsilon = 36'h100; delta = good;
    n_start = 0; n_done = 0; done_cyc = -1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      en          = !(cyc >= 1 && cyc <= 5);
      start       = (cyc >= 1 && cyc <= 3);
      solver_done = (cyc >= 1 && cyc <= 6) || cyc == 8 || cyc == 9;
      delta       = (cyc >= 8) ? spurious : good;
      if (en && solver_start) n_start++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 6) begin
        checks++;
        if ({busy, solver_start, done} !== 3'b100 || theta !== '0 || iter_count !== '0) begin
          errors++;
          $display("FAIL hold_in_wait: busy/ss/done=%b theta=%h iter=%0d, expected 100 0 0",
                   {busy, solver_start, done}, theta, iter_count);
        end
      end
      @(posedge clk); #1;
    end
    en = 1'b1; start = 1'b0; solver_done = 1'b0;
    checks++;
    if (done_cyc !== 14 || n_done !== 1 || n_start !== 1) begin
      errors++;
      $display("FAIL handshake_timing: done_cyc=%0d done=%0d start=%0d, expected 14 1 1",
               done_cyc, n_done, n_start);
    end
    for (int i = 0; i < NJ; i++) exp_theta[i] = 36'h80;
    checks++;
    if (theta !== exp_theta || iter_count !== IW'(1) || converged !== 1'b1) begin
      errors++;
      $display("FAIL handshake_result: theta=%h iter=%0d conv=%b, expected %h 1 1",
               theta, iter_count, converged, exp_theta);
    end
  endtask

  task automatic test_saturation();
    init_param = '0; delta = '0; joint_lock = '0; epsilon = 36'h101;
    init_param[0] = 36'h7_FFFF_FFF0;
    delta[0]      = 36'h100;
    exp_theta     = '0;
    exp_theta[0]  = 36'h7_FFFF_FFFF;
    run_solve(0, 200);
    checks++;
    if (theta !== exp_theta || converged !== 1'b1) begin
      errors++;
      $display("FAIL sat_positive: theta=%h conv=%b, expected %h 1", theta, converged, exp_theta);
    end
    init_param[0] = 36'h8_0000_0010;
    delta[0]      = 36'hF_FFFF_FF00;
    exp_theta[0]  = 36'h8_0000_0000;
    run_solve(0, 200);
    checks++;
    if (theta !== exp_theta || iter_count !== IW'(1)) begin
      errors++;
      $display("FAIL sat_negative: theta=%h iter=%0d, expected %h 1", theta, iter_count, exp_theta);
    end
  endtask

  task automatic test_lock_minval();
    init_param = '0; delta = '0; epsilon = 36'h100;
    init_param[0] = 36'h0_0001_2345;
    delta[0]      = 36'h8_0000_0000;
    joint_lock    = 6'b000001;
    exp_theta     = '0;
    exp_theta[0]  = 36'h0_0001_2345;
    run_solve(0, 200);
    checks++;
    if (theta !== exp_theta || converged !== 1'b1 || iter_count !== IW'(1) || done_cyc !== 9) begin
      errors++;
      $display("FAIL lock_converge: theta=%h conv=%b iter=%0d done_cyc=%0d, expected %h 1 1 9",
               theta, converged, iter_count, done_cyc, exp_theta);
    end
    joint_lock   = '0;
    exp_theta[0] = 36'h8_0000_0000;
    run_solve(0, 2000);
    checks++;
    if (theta !== exp_theta || converged !== 1'b0 || iter_count !== IW'(MI)) begin
      errors++;
      $display("FAIL minval_blocks: theta=%h conv=%b iter=%0d, expected %h 0 64",
               theta, converged, iter_count, exp_theta);
    end
  endtask

  task automatic test_epsilon();
    init_param = '0; joint_lock = '0; epsilon = 36'h80;
    for (int i = 0; i < NJ; i++) delta[i] = 36'h80;
    for (int i = 0; i < NJ; i++) exp_theta[i] = 36'h2000;
    run_solve(0, 2000);
    checks++;
    if (theta !== exp_theta || converged !== 1'b0 || iter_count !== IW'(MI)) begin
      errors++;
      $display("FAIL eps_equal: theta=%h conv=%b iter=%0d, expected %h 0 64",
               theta, converged, iter_count, exp_theta);
    end
    epsilon = 36'hF_FFFF_FFFF;
    delta   = '0;
    for (int i = 0; i < NJ; i++) init_param[i] = 36'h1000;
    for (int i = 0; i < NJ; i++) exp_theta[i] = 36'h1000;
    run_solve(0, 2000);
    checks++;
    if (theta !== exp_theta || converged !== 1'b0 || iter_count !== IW'(MI)) begin
      errors++;
      $display("FAIL eps_negative: theta=%h conv=%b iter=%0d, expected %h 0 64",
               theta, converged, iter_count, exp_theta);
    end
  endtask

  task automatic test_iter_limit();
    init_param = '0; joint_lock = '0; epsilon = 36'h100;
    for (int i = 0; i < NJ; i++) delta[i] = 36'h1_0000;
    for (int i = 0; i < NJ; i++) exp_theta[i] = 36'h40_0000;
    run_solve(0, 2000);
    checks++;
    if (theta !== exp_theta || converged !== 1'b0 || iter_count !== IW'(MI)) begin
      errors++;
      $display("FAIL limit_result: theta=%h conv=%b iter=%0d, expected %h 0 64",
               theta, converged, iter_count, exp_theta);
    end
    checks++;
    if (n_start !== MI || n_done !== 1 || done_cyc !== 576) begin
      errors++;
      $display("FAIL limit_pulses: start=%0d done=%0d done_cyc=%0d, expected 64 1 576",
               n_start, n_done, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    init_param = '0; joint_lock = '0; epsilon = 36'h100;
    for (int i = 0; i < NJ; i++) delta[i] = 36'h80;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // cycle 0 ISSUE, 1 WAIT (answered), 2..7 UPDATE; j=3 at cycle 5
    for (int cyc = 0; cyc < 5; cyc++) begin
      solver_done = (cyc == 1);
      @(posedge clk); #1;
    end
    solver_done = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if ({busy, done, solver_start, converged} !== 4'b0000 || theta !== '0 || iter_count !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: flags=%b theta=%h iter=%0d, expected 0000 0 0",
               {busy, done, solver_start, converged}, theta, iter_count);
    end
    n_done = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (done || busy) n_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: %0d active cycles after reset, expected 0", n_done);
    end
    for (int i = 0; i < NJ; i++) exp_theta[i] = 36'h80;
    run_solve(1, 200);
    checks++;
    if (theta !== exp_theta || converged !== 1'b1 || iter_count !== IW'(1) || done_cyc !== 10) begin
      errors++;
      $display("FAIL mid_reset_rerun: theta=%h conv=%b iter=%0d done_cyc=%0d, expected %h 1 1 10",
               theta, converged, iter_count, done_cyc, exp_theta);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_handshake();
    test_saturation();
    test_lock_minval();
    test_epsilon();
    test_iter_limit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
